// File: rtl/id_ex_control_if.sv
// ID/EX boundary bundle: decode-side inputs and stall from/to ID, registered controls towards EX.
// The module drives the slave side; the IF/ID stage or a testbench drives the master side.
interface id_ex_control_if #(
    parameter int XLEN = 64
);
    logic [31:0]     instr_i;
    logic            instr_valid_i;
    logic            flush_i;
    logic            stall_o;
    logic            ex_valid_o;
    logic            ex_reg_write_o;
    logic            ex_mem_read_o;
    logic            ex_mem_write_o;
    logic            ex_mem_to_reg_o;
    logic            ex_alu_src_o;
    logic            ex_branch_o;
    logic [1:0]      ex_alu_op_o;
    logic [6:0]      ex_funct7_o;
    logic [2:0]      ex_funct3_o;
    logic [4:0]      ex_rs1_o;
    logic [4:0]      ex_rs2_o;
    logic [4:0]      ex_rd_o;
    logic [XLEN-1:0] ex_imm_o;
    logic            ex_illegal_o;

    modport master (
        output instr_i, instr_valid_i, flush_i,
        input  stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_mem_to_reg_o, ex_alu_src_o, ex_branch_o, ex_alu_op_o, ex_funct7_o,
               ex_funct3_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o, ex_illegal_o
    );

    modport slave (
        input  instr_i, instr_valid_i, flush_i,
        output stall_o, ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_mem_to_reg_o, ex_alu_src_o, ex_branch_o, ex_alu_op_o, ex_funct7_o,
               ex_funct3_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_imm_o, ex_illegal_o
    );
endinterface

// File: rtl/id_ex_control.sv
// RV64 subset main decoder (ld/sd/beq/add/sub/and/or) plus the ID/EX pipeline register.
// Define ID_EX_HAZARD_EN to enable load-use stall detection; otherwise stall_o is tied low.
module id_ex_control #(
    parameter int XLEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_control_if.slave   bus
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    typedef struct packed {
        logic            valid;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            memToReg;
        logic            aluSrc;
        logic            branch;
        logic [1:0]      aluOp;
        logic [6:0]      funct7;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } exCtrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       hazard;
    exCtrl_t    decoded;
    exCtrl_t    exCtrl_d;
    exCtrl_t    exCtrl_q;

    assign opcode = bus.instr_i[6:0];
    assign funct3 = bus.instr_i[14:12];
    assign funct7 = bus.instr_i[31:25];

    always_comb begin
        decoded = '0;
        legal   = 1'b0;
        case (opcode)
            OpLoad: begin
                if (funct3 == 3'b011) begin
                    legal            = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.memRead  = 1'b1;
                    decoded.memToReg = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.imm      = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:20]};
                end
            end
            OpStore: begin
                if (funct3 == 3'b011) begin
                    legal            = 1'b1;
                    decoded.memWrite = 1'b1;
                    decoded.aluSrc   = 1'b1;
                    decoded.imm      = {{(XLEN-12){bus.instr_i[31]}}, bus.instr_i[31:25],
                                        bus.instr_i[11:7]};
                end
            end
            OpBranch: begin
                if (funct3 == 3'b000) begin
                    legal          = 1'b1;
                    decoded.branch = 1'b1;
                    decoded.aluOp  = 2'b01;
                    decoded.imm    = {{(XLEN-13){bus.instr_i[31]}}, bus.instr_i[31],
                                      bus.instr_i[7], bus.instr_i[30:25],
                                      bus.instr_i[11:8], 1'b0};
                end
            end
            OpReg: begin
                // add/or/and share funct7 0; only sub uses the alternate funct7
                if (((funct7 == 7'b0000000) &&
                     ((funct3 == 3'b000) || (funct3 == 3'b110) || (funct3 == 3'b111))) ||
                    ((funct7 == 7'b0100000) && (funct3 == 3'b000))) begin
                    legal            = 1'b1;
                    decoded.regWrite = 1'b1;
                    decoded.aluOp    = 2'b10;
                end
            end
            default: legal = 1'b0;
        endcase

        if (legal) begin
            decoded.valid  = 1'b1;
            decoded.funct7 = funct7;
            decoded.funct3 = funct3;
            decoded.rs1    = bus.instr_i[19:15];
            decoded.rs2    = bus.instr_i[24:20];
            decoded.rd     = bus.instr_i[11:7];
        end else begin
            decoded         = '0;
            decoded.illegal = 1'b1;
        end
    end

`ifdef ID_EX_HAZARD_EN
    logic rs2Used;
    assign rs2Used = legal && (opcode != OpLoad);
    assign hazard  = exCtrl_q.valid && exCtrl_q.memRead && (exCtrl_q.rd != 5'd0) &&
                     bus.instr_valid_i &&
                     ((exCtrl_q.rd == bus.instr_i[19:15]) ||
                      (rs2Used && (exCtrl_q.rd == bus.instr_i[24:20])));
`else
    assign hazard = 1'b0;
`endif

    assign bus.stall_o = hazard && !bus.flush_i;

    // Flush, hazard and an empty ID slot all load the same all-zero bubble.
    always_comb begin
        exCtrl_d = '0;
        if (bus.flush_i) begin
            exCtrl_d = '0;
        end else if (hazard) begin
            exCtrl_d = '0;
        end else if (!bus.instr_valid_i) begin
            exCtrl_d = '0;
        end else begin
            exCtrl_d = decoded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exCtrl_q <= '0;
        end else begin
            exCtrl_q <= exCtrl_d;
        end
    end

    assign bus.ex_valid_o      = exCtrl_q.valid;
    assign bus.ex_reg_write_o  = exCtrl_q.regWrite;
    assign bus.ex_mem_read_o   = exCtrl_q.memRead;
    assign bus.ex_mem_write_o  = exCtrl_q.memWrite;
    assign bus.ex_mem_to_reg_o = exCtrl_q.memToReg;
    assign bus.ex_alu_src_o    = exCtrl_q.aluSrc;
    assign bus.ex_branch_o     = exCtrl_q.branch;
    assign bus.ex_alu_op_o     = exCtrl_q.aluOp;
    assign bus.ex_funct7_o     = exCtrl_q.funct7;
    assign bus.ex_funct3_o     = exCtrl_q.funct3;
    assign bus.ex_rs1_o        = exCtrl_q.rs1;
    assign bus.ex_rs2_o        = exCtrl_q.rs2;
    assign bus.ex_rd_o         = exCtrl_q.rd;
    assign bus.ex_imm_o        = exCtrl_q.imm;
    assign bus.ex_illegal_o    = exCtrl_q.illegal;
endmodule
